// File: rtl/audio_sched_pkg.sv
// Shared types and elaboration helpers for the PWM-audio sample scheduler.
package audio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    LOAD      = 2'd2,
    SHIFT     = 2'd3
  } state_t;

  function automatic int calc_div(input int sys, input int samp);
    return sys / samp;
  endfunction

  // A single requester still needs a one-bit grant index.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_sample_scheduler_tick_gen.sv
// Sample-period tick generator: registered one-cycle pulse every DIV cycles while enabled.
module sample_tick_gen
  import audio_sched_pkg::*;
#(
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic enable_i,
  output logic tick_o
);

  localparam int DIV = calc_div(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] r_count;
  logic          r_tick;

  // The tick is registered from the pre-terminal count so it lines up with count == DIV-1.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (!enable_i) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
      r_tick  <= (r_count == PRE);
    end
  end

  assign tick_o = r_tick;

endmodule

// File: rtl/audio_sample_scheduler.sv
// Round-robin scheduler feeding one word per sample period to the PWM serializer.
// Optional AUDIO_SCHED_STATS_EN adds saturating underrun/late event counters.
module audio_sample_scheduler
  import audio_sched_pkg::*;
#(
  parameter int                     WORD_LENGTH        = 16,
  parameter int                     SYSTEM_FREQUENCY   = 100000000,
  parameter int                     SAMPLING_FREQUENCY = 1000000,
  parameter int                     NUM_REQ            = 2,
  parameter logic [WORD_LENGTH-1:0] SILENCE_WORD       = '0,
  localparam int                    GW                 = grant_width(NUM_REQ)
) (
  input  logic                           clock_i,
  input  logic                           reset_ni,
  input  logic                           enable_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           ser_enable_o,
  output logic [WORD_LENGTH-1:0]         ser_data_o,
  input  logic                           ser_done_i,
  output logic [GW-1:0]                  grant_o,
  output logic                           tick_o,
  output logic                           underrun_o,
  output logic                           late_o
`ifdef AUDIO_SCHED_STATS_EN
  ,
  output logic [15:0]                    underrun_count_o,
  output logic [15:0]                    late_count_o
`endif
);

  localparam int DIV = calc_div(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);

  // A word needs LOAD + WORD_LENGTH shift cycles + done within one period.
  generate
    if (DIV < WORD_LENGTH + 3) begin : g_div_check
      $error("audio_sample_scheduler: sample period shorter than WORD_LENGTH+3 cycles");
    end
  endgenerate

  state_t                 r_state, w_next;
  logic [GW-1:0]          r_grant, w_pick;
  logic                   w_found;
  logic [WORD_LENGTH-1:0] r_ser_data, w_load_word;
  logic                   w_tick;

  sample_tick_gen #(
    .SYSTEM_FREQUENCY  (SYSTEM_FREQUENCY),
    .SAMPLING_FREQUENCY(SAMPLING_FREQUENCY)
  ) u_tick (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .enable_i(enable_i),
    .tick_o  (w_tick)
  );

  // Search starts one past the last grant so silence words do not disturb fairness.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_found && req_valid_i[k] && (k == (int'(r_grant) + i) % NUM_REQ)) begin
          w_found = 1'b1;
          w_pick  = GW'(k);
        end
      end
    end
  end

  always_comb begin
    w_load_word = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant == GW'(k)) begin
        w_load_word    = req_data_i[k*WORD_LENGTH +: WORD_LENGTH];
        req_ready_o[k] = (r_state == LOAD) && enable_i;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    underrun_o = 1'b0;
    late_o     = 1'b0;
    case (r_state)
      IDLE: if (enable_i) w_next = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable_i) begin
          w_next = IDLE;
        end else if (w_tick) begin
          w_next     = w_found ? LOAD : SHIFT;
          underrun_o = !w_found;
        end
      end
      // Enable dropping before the accept abandons the load so no ready is issued.
      LOAD: begin
        late_o = w_tick;
        w_next = enable_i ? SHIFT : IDLE;
      end
      SHIFT: begin
        late_o = w_tick;
        if (ser_done_i) w_next = enable_i ? WAIT_TICK : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= IDLE;
      r_grant    <= GW'(NUM_REQ - 1);
      r_ser_data <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == WAIT_TICK) && enable_i && w_tick) begin
        if (w_found) r_grant    <= w_pick;
        else         r_ser_data <= SILENCE_WORD;
      end
      if ((r_state == LOAD) && enable_i) r_ser_data <= w_load_word;
    end
  end

  assign ser_enable_o = (r_state == SHIFT) && !ser_done_i;
  assign ser_data_o   = r_ser_data;
  assign grant_o      = r_grant;
  assign tick_o       = w_tick;

`ifdef AUDIO_SCHED_STATS_EN
  logic [15:0] r_underrun_cnt, r_late_cnt;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_underrun_cnt <= '0;
      r_late_cnt     <= '0;
    end else if (!enable_i) begin
      r_underrun_cnt <= '0;
      r_late_cnt     <= '0;
    end else begin
      if (underrun_o && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (late_o && (r_late_cnt != 16'hFFFF))         r_late_cnt     <= r_late_cnt + 16'd1;
    end
  end

  assign underrun_count_o = r_underrun_cnt;
  assign late_count_o     = r_late_cnt;
`endif

endmodule
